bram_rd_stream: RTL
===================

# bram_rd_stream

Read-side client for a 1R1W block RAM with a registered read port. It accepts read requests on a valid/ready address channel and drives the RAM's `rd_en`/`rd_addr`. It captures `rd_data` one cycle after each issue and returns the data in order on a valid/ready response channel. It sits between a pipeline stage, such as fetch or a table walker, and any RAM with one-cycle read latency. It sustains one read per cycle under no backpressure and loses no data under backpressure.

## Interface
- `ADDR_WIDTH`, 4, RAM address width.
- `DATA_WIDTH`, 8, RAM data width.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request address valid.
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`.
- `req_addr`  in  ADDR_WIDTH  read address.
- `rsp_valid`  out  1  response data valid.
- `rsp_ready`  in  1  consumer takes the response this cycle when `rsp_valid && rsp_ready`.
- `rsp_data`  out  DATA_WIDTH  response data, from a register.
- `mem_rd_en`  out  1  RAM read enable.
- `mem_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `mem_rd_data`  in  DATA_WIDTH  RAM read data, valid in the cycle after `mem_rd_en`.

## Operation
- Accept: `acc = req_valid && req_ready`.
  - `mem_rd_en = acc` and `mem_rd_addr = req_addr`, both combinational.
  - `mem_rd_addr` is don't-care when `acc` is 0.
- In-flight flag `pend`:
  - `pend <= acc`.
  - When `pend` is 1, `mem_rd_data` is captured into the response buffer at the end of the cycle.
- Response buffer:
  - 2-entry in-order FIFO: registered head/tail entries, 2-bit occupancy `occ` (0..2).
  - `rsp_valid = (occ != 0)`; `rsp_data` = head entry.
- Pop: `pop = rsp_valid && rsp_ready`. A same-cycle capture and pop both apply: `occ` is unchanged and the tail moves to the head.
- Credit rule: `req_ready = rst_n && (occ + pend - pop < 2)`.
  - This guarantees buffer space for every issued read, so a capture can never be dropped.
  - `req_ready` depends combinationally on `rsp_ready`. No path from `req_valid` to `req_ready` is allowed.
- Ordering: responses return strictly in request order.
- Data integrity: each response equals the RAM content at its address as returned by the RAM. Write collisions resolve inside the RAM and are not handled here.
- Reset, asynchronous, any time:
  - `pend=0`, `occ=0`, buffer entries 0, `rsp_valid=0`, `rsp_data=0`.
  - `req_ready=0` while `rst_n` is low, so `mem_rd_en=0`.
  - In-flight reads and buffered responses are discarded. The first request after release is treated as fresh.

## Timing
- Request accepted in cycle N:
  - `mem_rd_en=1` in N.
  - RAM data present in N+1, captured at the end of N+1.
  - `rsp_valid=1` in N+2.
  - Latency: 2 cycles, request handshake to response valid.
- Throughput: 1 request/cycle sustained while `rsp_ready=1`, reached at steady state `occ=1`, `pend=1`.
- Backpressure:
  - With `rsp_ready=0`, at most 2 requests are accepted beyond the last pop.
  - `req_ready` drops in the cycle where `occ + pend = 2`.
  - `req_ready` rises again in the same cycle as a pop.
- Empty: `occ=0`, `pend=0` gives `rsp_valid=0` and `req_ready=1`.
- Full: `occ=2` gives `req_ready = pop`.
- `occ` saturation: `occ` never exceeds 2. `occ=2` with `pend=1` is unreachable; the bench asserts this.
- After `rst_n` release: `req_ready=1` in the first cycle with `rst_n` high.

## Test plan
- Single read: RAM[3]=0xA5; request addr 3 in cycle 0 with `rsp_ready=1` -> `mem_rd_en=1`/addr 3 in cycle 0, `rsp_valid=1` with `rsp_data=0xA5` in cycle 2 only.
- Streaming: RAM[i]=i+0x10; requests addr 0..15 back-to-back with `rsp_ready=1` -> `req_ready` stays 1; responses 0x10..0x1F on consecutive cycles 2..17.
- Backpressure:
  - Stimulus: `rsp_ready=0`, `req_valid` held high over addrs 0,1,2,...
  - Required before release: exactly 2 requests accepted; `req_ready=0` from cycle 2; `occ=2`.
  - Stimulus: raise `rsp_ready` in cycle 6.
  - Required after release: responses for addrs 0,1,2,... in order, no loss, no duplicates, `req_ready=1` in cycle 6.
- Random `rsp_ready` toggling (50%) over 1000 random-address requests -> scoreboard matches every response in order; `occ <= 2` always; `mem_rd_en` only when `req_ready` is high.
- Reset mid-operation:
  - Stimulus: `occ=2`, `pend=0`; assert `rst_n` low between clock edges.
  - Required immediately: `rsp_valid=0`, `rsp_data=0`, `req_ready=0`.
  - Stimulus: release reset, then request addr 5 (RAM[5]=0x3C).
  - Required: exactly one response, 0x3C, 2 cycles after acceptance; no stale data.
- Pop/capture coincidence: `occ=1`, `pend=1`, `rsp_ready=1` -> `occ` stays 1, head updates to the new data, `req_ready=1`.

Source files
------------

// File: rtl/bram_rd_stream_if.sv
// Signal bundle between a read requester, the read-stream client and the RAM read port.
// The slave modport is the client's view; the master modport drives the client.
interface bram_rd_stream_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_data, mem_rd_en, mem_rd_addr
  );

  modport master (
    output req_valid, req_addr, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_data, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/bram_rd_stream.sv
// Read-side client for a RAM with a one-cycle registered read port: issues reads on
// request handshakes and returns the data in order through a 2-entry response buffer.
module bram_rd_stream #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  bram_rd_stream_if.slave bus
);
  logic                  acc_s;
  logic                  pop_s;
  logic                  req_ready_s;
  logic [2:0]            credit_s;
  logic                  pend_q;
  logic                  pend_d;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;

  // Credit: buffered + in-flight - leaving this cycle must leave room for one more read
  always_comb begin
    pop_s       = (occ_q != 2'd0) && bus.rsp_ready;
    credit_s    = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_s};
    req_ready_s = rst_n && (credit_s < 3'd2);
    acc_s       = bus.req_valid && req_ready_s;
    pend_d      = acc_s;
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.mem_rd_en   = acc_s;
  assign bus.mem_rd_addr = bus.req_addr;
  assign bus.rsp_valid   = (occ_q != 2'd0);
  assign bus.rsp_data    = head_q;

  // Response buffer next state; capture and pop in the same cycle shift tail into head
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({pend_q, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = bus.mem_rd_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = bus.mem_rd_data;
          occ_d  = 2'd2;
        end else begin
          occ_d  = occ_q;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.mem_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.mem_rd_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      pend_q <= pend_d;
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  bram_rd_stream_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .occ_i       (occ_q),
    .pend_i      (pend_q),
    .req_ready_i (req_ready_s),
    .mem_rd_en_i (acc_s)
  );
endmodule

// Invariants of the response buffer and issue path.
module bram_rd_stream_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] occ_i,
  input logic       pend_i,
  input logic       req_ready_i,
  input logic       mem_rd_en_i
);
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ_i <= 2'd2);
  a_full_no_pend: assert property (@(posedge clk) disable iff (!rst_n) !(occ_i == 2'd2 && pend_i));
  a_en_needs_ready: assert property (@(posedge clk) disable iff (!rst_n) mem_rd_en_i |-> req_ready_i);
endmodule
